// File: rtl/dm_stream_dma_if.sv
// dm_stream_dma_if: command, write-stream, read-stream and data-memory signals of the stream DMA.
interface dm_stream_dma_if #(parameter int DM_AW = 10, parameter int DM_DW = 32);
  logic             cmd_vld, cmd_rdy, cmd_wr;
  logic [DM_AW-1:0] cmd_addr;
  logic [DM_AW:0]   cmd_len;
  logic [DM_DW-1:0] s_data;
  logic             s_vld, s_rdy;
  logic [DM_DW-1:0] m_data;
  logic             m_vld, m_rdy;
  logic [DM_AW-1:0] mem_addr;
  logic [DM_DW-1:0] mem_wdata, mem_rdata;
  logic             mem_wr_en, mem_rd_en, mem_rdata_vld;
  logic             done, err;
  modport master (
    input  cmd_vld, cmd_wr, cmd_addr, cmd_len, s_data, s_vld, m_rdy, mem_rdata, mem_rdata_vld,
    output cmd_rdy, s_rdy, m_data, m_vld, mem_addr, mem_wdata, mem_wr_en, mem_rd_en, done, err
  );
  modport slave (
    output cmd_vld, cmd_wr, cmd_addr, cmd_len, s_data, s_vld, m_rdy, mem_rdata, mem_rdata_vld,
    input  cmd_rdy, s_rdy, m_data, m_vld, mem_addr, mem_wdata, mem_wr_en, mem_rd_en, done, err
  );
endinterface

// File: rtl/dm_stream_dma.sv
// dm_stream_dma: stream<->data-memory DMA with credit-limited read-return buffer.
// Define DM_DMA_ERR_EN to build the sticky address-wrap / spurious-read-data error flag.
module dm_stream_dma #(
  parameter int DM_AW    = 10,
  parameter int DM_DW    = 32,
  parameter int RB_DEPTH = 4
) (
  input logic clk,
  input logic rst_n,
  dm_stream_dma_if.master bus
);
  localparam int RB_AW = $clog2(RB_DEPTH);
  localparam logic [RB_AW+1:0] RB_LIM = (RB_AW+2)'(RB_DEPTH);
  typedef enum logic [1:0] {IDLE, WRITE, READ, DRAIN} state_t;
  state_t           state_q, state_d;
  logic [DM_AW-1:0] cnt_q, cnt_d, addr_q, addr_d;
  logic [DM_AW:0]   rem_q, rem_d;
  logic [DM_DW-1:0] wdata_q, wdata_d;
  logic             wr_en_q, wr_en_d, rd_en_q, rd_en_d, s_rdy_q, s_rdy_d, done_q, done_d;
  logic [RB_AW:0]   wp_q, wp_d, rp_q, rp_d, out_q, out_d, occ;
  logic [RB_AW+1:0] credit;
  logic [DM_DW-1:0] rb_q [RB_DEPTH];
  logic             rb_we, pop;
  assign occ    = wp_q - rp_q;
  assign credit = {1'b0, out_q} + {1'b0, occ};
  // Returned data is only accepted against a read still owed, which also drops stale data after reset.
  assign rb_we  = bus.mem_rdata_vld && out_q != '0;
  assign pop    = bus.m_vld && bus.m_rdy;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    addr_d  = addr_q;
    wdata_d = '0;
    wr_en_d = 1'b0;
    rd_en_d = 1'b0;
    s_rdy_d = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      IDLE: if (bus.cmd_vld) begin
        cnt_d   = bus.cmd_addr;
        rem_d   = bus.cmd_len;
        done_d  = bus.cmd_len == '0;
        s_rdy_d = bus.cmd_len != '0 && bus.cmd_wr;
        state_d = bus.cmd_len == '0 ? IDLE : bus.cmd_wr ? WRITE : READ;
      end
      WRITE: begin
        if (bus.s_vld && s_rdy_q) begin
          wr_en_d = 1'b1;
          addr_d  = cnt_q;
          wdata_d = bus.s_data;
          cnt_d   = cnt_q + DM_AW'(1);
          rem_d   = rem_q - (DM_AW+1)'(1);
          done_d  = rem_d == '0;
          state_d = rem_d == '0 ? IDLE : WRITE;
        end
        s_rdy_d = rem_d != '0;
      end
      READ: begin
        rd_en_d = rem_q != '0 && credit < RB_LIM;
        if (rd_en_d) begin
          addr_d = cnt_q;
          cnt_d  = cnt_q + DM_AW'(1);
          rem_d  = rem_q - (DM_AW+1)'(1);
        end
        state_d = rem_d == '0 ? DRAIN : READ;
      end
      DRAIN: if (pop && occ == (RB_AW+1)'(1) && out_q == '0) begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    wp_d  = wp_q + (RB_AW+1)'(rb_we);
    rp_d  = rp_q + (RB_AW+1)'(pop);
    out_d = out_q + (RB_AW+1)'(rd_en_d) - (RB_AW+1)'(rb_we);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      wr_en_q <= 1'b0;
      rd_en_q <= 1'b0;
      s_rdy_q <= 1'b0;
      done_q  <= 1'b0;
      wp_q    <= '0;
      rp_q    <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wr_en_q <= wr_en_d;
      rd_en_q <= rd_en_d;
      s_rdy_q <= s_rdy_d;
      done_q  <= done_d;
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      out_q   <= out_d;
    end
  always_ff @(posedge clk)
    if (rb_we) rb_q[wp_q[RB_AW-1:0]] <= bus.mem_rdata;
  assign bus.cmd_rdy   = state_q == IDLE;
  assign bus.s_rdy     = s_rdy_q;
  assign bus.m_vld     = occ != '0;
  assign bus.m_data    = rb_q[rp_q[RB_AW-1:0]];
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.mem_wr_en = wr_en_q;
  assign bus.mem_rd_en = rd_en_q;
  assign bus.done      = done_q;
`ifdef DM_DMA_ERR_EN
  logic err_q, err_d;
  assign err_d = err_q || ((wr_en_d || rd_en_d) && cnt_q == '1) || (bus.mem_rdata_vld && out_q == '0);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= err_d;
  assign bus.err = err_q;
`else
  assign bus.err = 1'b0;
`endif
endmodule

// File: tb/tb_dm_stream_dma.sv
// tb_dm_stream_dma: directed scoreboard bench for dm_stream_dma with a 1-cycle-latency memory model.
module tb_dm_stream_dma;
`ifdef DM_DMA_ERR_EN
  localparam bit EXP_ERR = 1'b1;
`else
  localparam bit EXP_ERR = 1'b0;
`endif
  typedef struct { logic [9:0] a; logic [31:0] d; int c; } ent_t;
  logic clk, rst_n;
  int   cyc = 0, checks = 0, errors = 0, inflight = 0, req = 0, acc;
  bit   inj = 0, vld_q = 0;
  bit   seen [1024];
  logic [31:0] mem [1024];
  logic [31:0] rdata_q;
  ent_t q_wr[$], q_rd[$], q_m[$], q_dn[$];
  dm_stream_dma_if #(.DM_AW(10), .DM_DW(32)) bus ();
  dm_stream_dma #(.DM_AW(10), .DM_DW(32), .RB_DEPTH(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  initial clk = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) begin
    if (bus.mem_wr_en) begin
      mem[bus.mem_addr]  <= bus.mem_wdata;
      seen[bus.mem_addr] <= 1'b1;
    end
    vld_q   <= bus.mem_rd_en;
    rdata_q <= seen[bus.mem_addr] ? mem[bus.mem_addr] : (32'hC000_0000 | 32'(bus.mem_addr));
  end
  assign bus.mem_rdata     = rdata_q;
  assign bus.mem_rdata_vld = vld_q | inj;
  task automatic chk(input bit ok, input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h want %h", nm, cyc, act, exp);
    end
  endtask
  always @(negedge clk) begin
    ent_t e;
    if (!rst_n) begin
      inflight = 0;
      chk({bus.mem_wr_en, bus.mem_rd_en, bus.m_vld, bus.s_rdy, bus.done, bus.err, bus.cmd_rdy} == 7'b0000001,
          "reset_flags", 32'({bus.mem_wr_en, bus.mem_rd_en, bus.m_vld, bus.s_rdy, bus.done, bus.err, bus.cmd_rdy}), 32'h1);
      chk(bus.mem_addr == 0 && bus.mem_wdata == 0, "reset_bus", 32'(bus.mem_addr) | bus.mem_wdata, 0);
    end else begin
      chk(!(bus.mem_wr_en && bus.mem_rd_en), "wr_rd_excl", 32'({bus.mem_wr_en, bus.mem_rd_en}), 0);
      chk(bus.mem_wr_en || bus.mem_wdata == 0, "wdata_idle", bus.mem_wdata, 0);
      if (bus.mem_wr_en) begin
        if (q_wr.size() == 0) chk(0, "wr_unexpected", 32'(bus.mem_addr), 0);
        else begin
          e = q_wr.pop_front();
          chk(bus.mem_addr == e.a, "wr_addr", 32'(bus.mem_addr), 32'(e.a));
          chk(bus.mem_wdata == e.d, "wr_data", bus.mem_wdata, e.d);
          if (e.c >= 0) chk(cyc == e.c, "wr_cycle", cyc, e.c);
        end
      end
      if (bus.mem_rd_en) begin
        inflight++;
        chk(inflight <= 4, "rd_credit", inflight, 4);
        if (q_rd.size() == 0) chk(0, "rd_unexpected", 32'(bus.mem_addr), 0);
        else begin
          e = q_rd.pop_front();
          chk(bus.mem_addr == e.a, "rd_addr", 32'(bus.mem_addr), 32'(e.a));
          if (e.c >= 0) chk(cyc == e.c, "rd_cycle", cyc, e.c);
        end
      end
      if (bus.m_vld && bus.m_rdy) begin
        inflight--;
        if (q_m.size() == 0) chk(0, "m_unexpected", bus.m_data, 0);
        else begin
          e = q_m.pop_front();
          chk(bus.m_data == e.d, "m_data", bus.m_data, e.d);
          if (e.c >= 0) chk(cyc == e.c, "m_cycle", cyc, e.c);
        end
      end
      if (bus.done) begin
        chk(bus.cmd_rdy == 1'b1, "cmd_rdy_at_done", 32'(bus.cmd_rdy), 1);
        if (q_dn.size() == 0) chk(0, "done_unexpected", cyc, 0);
        else begin
          e = q_dn.pop_front();
          if (e.c >= 0) chk(cyc == e.c, "done_cycle", cyc, e.c);
        end
      end
      if (req == 1) begin
        chk(q_wr.size() == 0, "wr_missing", q_wr.size(), 0);
        chk(q_rd.size() == 0, "rd_missing", q_rd.size(), 0);
        chk(q_m.size() == 0, "m_missing", q_m.size(), 0);
        chk(q_dn.size() == 0, "done_missing", q_dn.size(), 0);
      end
      if (req == 2) chk(bus.err == EXP_ERR, "err_flag", 32'(bus.err), 32'(EXP_ERR));
    end
  end
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic request(input int k);
    req = k;
    step(1);
    req = 0;
  endtask
  task automatic cmd(input bit wr, input logic [9:0] a, input logic [10:0] n, output int ac);
    bus.cmd_vld = 1; bus.cmd_wr = wr; bus.cmd_addr = a; bus.cmd_len = n;
    ac = cyc + 1;
    step(1);
    bus.cmd_vld = 0;
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
  initial begin
    logic [9:0] wrap_a [4];
    wrap_a = '{10'h3FE, 10'h3FF, 10'h000, 10'h001};
    rst_n = 0;
    bus.cmd_vld = 0; bus.cmd_wr = 0; bus.cmd_addr = 0; bus.cmd_len = 0;
    bus.s_data = 0; bus.s_vld = 0; bus.m_rdy = 1;
    step(3);
    rst_n = 1;
    step(2);
    cmd(1, 10'h010, 11'd4, acc);
    for (int i = 0; i < 4; i++) q_wr.push_back('{10'(16 + i), 32'(160 + i), acc + 1 + i});
    q_dn.push_back('{0, 0, acc + 4});
    for (int i = 0; i < 4; i++) begin
      bus.s_vld = 1; bus.s_data = 32'(160 + i);
      @(negedge clk);
      while (!bus.s_rdy) @(negedge clk);
      step(1);
    end
    bus.s_vld = 0;
    step(6);
    request(1);
    cmd(0, 10'h010, 11'd4, acc);
    for (int i = 0; i < 4; i++) begin
      q_rd.push_back('{10'(16 + i), 0, acc + 1 + i});
      q_m.push_back('{0, 32'(160 + i), acc + 3 + i});
    end
    q_dn.push_back('{0, 0, acc + 7});
    step(12);
    request(1);
    cmd(0, 10'h155, 11'd0, acc);
    q_dn.push_back('{0, 0, acc});
    step(4);
    request(1);
    bus.m_rdy = 0;
    cmd(0, 10'h100, 11'd16, acc);
    for (int i = 0; i < 16; i++) begin
      q_rd.push_back('{10'(256 + i), 0, -1});
      q_m.push_back('{0, 32'hC000_0100 + 32'(i), -1});
    end
    q_dn.push_back('{0, 0, -1});
    step(10);
    bus.m_rdy = 1;
    step(30);
    request(1);
    cmd(0, 10'h3FE, 11'd4, acc);
    for (int i = 0; i < 4; i++) begin
      q_rd.push_back('{wrap_a[i], 0, acc + 1 + i});
      q_m.push_back('{0, 32'hC000_0000 | 32'(wrap_a[i]), acc + 3 + i});
    end
    q_dn.push_back('{0, 0, acc + 7});
    step(12);
    request(1);
    request(2);
    bus.m_rdy = 0;
    cmd(0, 10'h200, 11'd8, acc);
    for (int i = 0; i < 4; i++) q_rd.push_back('{10'(512 + i), 0, acc + 1 + i});
    step(5);
    rst_n = 0;
    step(1);
    rst_n = 1; inj = 1; bus.m_rdy = 1;
    step(1);
    inj = 0;
    step(4);
    request(1);
    cmd(0, 10'h010, 11'd2, acc);
    for (int i = 0; i < 2; i++) begin
      q_rd.push_back('{10'(16 + i), 0, acc + 1 + i});
      q_m.push_back('{0, 32'(160 + i), acc + 3 + i});
    end
    q_dn.push_back('{0, 0, acc + 5});
    step(10);
    request(1);
    step(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
